// File: rtl/apb_arb_pkg.sv
// Shared types and width helpers for the APB master arbiter.
// APB_TIMEOUT_EN (optional) enables the ACCESS-phase timeout in apb_master_arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner
);

  localparam logic [IDX_W:0] NREQ = (IDX_W + 1)'(NUM_REQ);

  logic             found;
  logic [IDX_W:0]   pos;

  // One extra bit on pos lets the wrap be a single subtract for any NUM_REQ.
  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    pos    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, rr_ptr} + (IDX_W + 1)'(i);
      if (pos >= NREQ) pos = pos - NREQ;
      if (!found && req[pos[IDX_W-1:0]]) begin
        found                   = 1'b1;
        grant[pos[IDX_W-1:0]]   = 1'b1;
        winner                  = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Round-robin sharing of one APB master port between NUM_REQ command sources.
// Define APB_TIMEOUT_EN to abandon ACCESS after TIMEOUT_CYCLES cycles without pready.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                          pclk,
  input  logic                          preset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  input  logic [NUM_REQ-1:0]            req_write,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [WIDTH-1:0]              rsp_rdata,
  output logic                          rsp_err,
  output logic                          psel,
  output logic                          penable,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic                          pwrite,
  output logic [WIDTH-1:0]              pwdata,
  input  logic [WIDTH-1:0]              prdata,
  input  logic                          pready,
  input  logic                          pslverr
);

  localparam int unsigned      IDX_W = idx_width(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_REQ - 1);

  apb_state_e              state;
  logic [IDX_W-1:0]        rr_ptr;
  logic [NUM_REQ-1:0]      win_oh;
  logic [NUM_REQ-1:0]      grant;
  logic [IDX_W-1:0]        winner;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [WIDTH-1:0]        sel_wdata;
  logic                    sel_write;
  logic                    timed_out;

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .grant   (grant),
    .winner  (winner)
  );

  // Gated by preset so every output reads 0 while reset is held.
  assign req_ready = (state == IDLE && !preset) ? grant : '0;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*WIDTH +: WIDTH];
        sel_write = req_write[i];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;

  // wait_cnt holds the number of ACCESS cycles already spent without pready.
  assign timed_out = (state == ACCESS) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wait_cnt <= '0;
    end else if (state == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !pready && !timed_out) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      win_oh    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            win_oh <= grant;
            paddr  <= sel_addr;
            pwdata <= sel_wdata;
            pwrite <= sel_write;
            rr_ptr <= (winner == LAST) ? '0 : winner + 1'b1;
            psel   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // A pready in the limit cycle takes precedence over the timeout.
          if (pready) begin
            rsp_valid <= win_oh;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end else if (timed_out) begin
            rsp_valid <= win_oh;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed scoreboard bench for apb_master_arbiter (timeout step active with APB_TIMEOUT_EN).
module tb_apb_master_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int AW = 8;

  logic              pclk = 1'b0;
  logic              preset;
  logic [N-1:0]      req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*W-1:0]    req_wdata;
  logic [W-1:0]      rsp_rdata, pwdata, prdata;
  logic              rsp_err, psel, penable, pwrite, pready, pslverr;
  logic [AW-1:0]     paddr;

  always #5 pclk = ~pclk;

  apb_master_arbiter #(
    .NUM_REQ        (N),
    .WIDTH          (W),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .pclk      (pclk),
    .preset    (preset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_write (req_write),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .paddr     (paddr),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  typedef struct {
    logic [N-1:0] who;
    logic [W-1:0] rdata;
    logic         err;
  } rsp_t;

  int          vectors = 0;
  int          miscompares = 0;
  rsp_t        sb[$];
  int          grants[$];
  int          mptr = 0;
  bit          busy = 0;
  bit          tmo_mode = 0;
  int          ws = 0;
  logic [W-1:0] rd_val = '0;
  logic        err_val = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [W-1:0]  cur_wdata = '0;
  logic          cur_write = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // APB slave: pready after ws wait cycles; junk on prdata/pslverr when not ready.
  initial begin
    int acc_cnt;
    acc_cnt = 0;
    pready  = 1'b0;
    prdata  = '0;
    pslverr = 1'b0;
    forever begin
      @(negedge pclk);
      if (psel && penable && preset !== 1'b1) begin
        pready = (acc_cnt == ws);
        acc_cnt++;
      end else begin
        pready  = 1'b0;
        acc_cnt = 0;
      end
      prdata  = pready ? rd_val : 32'hBAD0_BAD0;
      pslverr = pready ? err_val : 1'b1;
    end
  end

  // Monitor: response scoreboard, round-robin grant model, APB protocol checks.
  initial begin
    bit prev_psel, prev_pen;
    prev_psel = 0;
    prev_pen  = 0;
    forever begin
      @(negedge pclk);
      if (preset !== 1'b1) begin
        if (|rsp_valid) begin
          if (sb.size() == 0) begin
            check("rsp_unexpected", rsp_valid, '0);
          end else begin
            rsp_t e;
            e = sb.pop_front();
            check("sb_rsp_valid", rsp_valid, e.who);
            check("sb_rsp_rdata", rsp_rdata, e.rdata);
            check("sb_rsp_err", rsp_err, e.err);
          end
          busy = 0;
        end
        if (!busy && |req_valid) begin
          int w;
          bit found;
          logic [N-1:0] oh;
          rsp_t e;
          w = 0;
          found = 0;
          for (int k = 0; k < N; k++) begin
            int p;
            p = (mptr + k) % N;
            if (!found && req_valid[p]) begin
              found = 1;
              w = p;
            end
          end
          oh = '0;
          oh[w] = 1'b1;
          check("req_ready_grant", req_ready, oh);
          e.who   = oh;
          e.rdata = (req_write[w] || tmo_mode) ? '0 : rd_val;
          e.err   = tmo_mode ? 1'b1 : err_val;
          sb.push_back(e);
          cur_addr  = req_addr[w*AW +: AW];
          cur_wdata = req_wdata[w*W +: W];
          cur_write = req_write[w];
          grants.push_back(w);
          mptr = (w + 1) % N;
          busy = 1;
        end else begin
          check("req_ready_quiet", req_ready, '0);
        end
        if (psel) begin
          check("paddr_held", paddr, cur_addr);
          check("pwrite_held", pwrite, cur_write);
          check("pwdata_held", pwdata, cur_wdata);
        end
        if (penable) check("penable_needs_psel", psel, 1);
        if (penable && !prev_pen) check("setup_before_access", prev_psel, 1);
        prev_psel = psel;
        prev_pen  = penable;
      end else begin
        prev_psel = 0;
        prev_pen  = 0;
      end
    end
  end

  task automatic issue(input int idx, input logic [AW-1:0] a, input logic [W-1:0] d, input logic wr);
    @(posedge pclk); #1;
    req_addr[idx*AW +: AW] = a;
    req_wdata[idx*W +: W]  = d;
    req_write[idx]         = wr;
    req_valid[idx]         = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge pclk);
      if (req_ready[idx]) break;
    end
    check("accept_wait", req_ready[idx], 1);
    @(posedge pclk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge pclk);
      cycles++;
      if (|rsp_valid) break;
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 300; c++) begin
      @(negedge pclk);
      if (sb.size() == 0 && !busy) break;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    int cyc;
    preset    = 1'b1;
    req_valid = '1;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(negedge pclk);
    check("rst_req_ready", req_ready, '0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp", {rsp_err, rsp_rdata}, '0);
    check("rst_apb", {pwrite, paddr, pwdata}, '0);
    @(posedge pclk); #1;
    req_valid = '0;
    preset    = 1'b0;

    // Zero-wait write from requester 2: psel T+1, penable T+2, rsp T+3.
    ws = 0; rd_val = 32'hCAFE_F00D; err_val = 1'b0;
    @(posedge pclk); #1;
    req_addr[2*AW +: AW] = 8'h10;
    req_wdata[2*W +: W]  = 32'hDEAD_BEEF;
    req_write[2]         = 1'b1;
    req_valid            = 4'b0100;
    @(negedge pclk);
    check("t1_ready", req_ready, 4'b0100);
    @(posedge pclk); #1;
    req_valid = '0;
    @(negedge pclk);
    check("t1_setup", {psel, penable}, 2'b10);
    check("t1_paddr", paddr, 8'h10);
    check("t1_pwdata", pwdata, 32'hDEAD_BEEF);
    @(negedge pclk);
    check("t1_access", {psel, penable}, 2'b11);
    @(negedge pclk);
    check("t1_rsp_valid", rsp_valid, 4'b0100);
    check("t1_rsp_err", rsp_err, 0);
    check("t1_rsp_rdata", rsp_rdata, '0);

    // Read with three wait states from requester 1.
    ws = 3; rd_val = 32'h1234_5678;
    issue(1, 8'h44, 32'h0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge pclk);
      check("t2_psel", psel, 1);
      check("t2_paddr", paddr, 8'h44);
    end
    @(negedge pclk);
    check("t2_rsp_valid", rsp_valid, 4'b0010);
    check("t2_rsp_rdata", rsp_rdata, 32'h1234_5678);

    // Slave error on a write, then a clean write to confirm err is per-transfer.
    ws = 1; err_val = 1'b1; rd_val = 32'h55;
    issue(3, 8'hF0, 32'h0BAD_F00D, 1'b1);
    wait_rsp(cyc);
    check("t4_err_valid", rsp_valid, 4'b1000);
    check("t4_err", rsp_err, 1);
    check("t4_err_rdata", rsp_rdata, '0);
    err_val = 1'b0;
    issue(0, 8'h01, 32'h11, 1'b1);
    wait_rsp(cyc);
    check("t4_ok_valid", rsp_valid, 4'b0001);
    check("t4_ok_err", rsp_err, 0);

    // Reset pulse in the middle of ACCESS.
    ws = 50;
    issue(1, 8'h22, 32'h0, 1'b0);
    repeat (3) @(negedge pclk);
    check("t5_in_access", {psel, penable}, 2'b11);
    #1;
    preset = 1'b1;
    #1;
    check("t5_async_drop", {psel, penable}, 2'b00);
    check("t5_no_rsp", rsp_valid, '0);
    sb.delete();
    busy = 0;
    mptr = 0;
    ws   = 0;
    @(negedge pclk);
    @(posedge pclk); #1;
    preset = 1'b0;
    repeat (2) begin
      @(negedge pclk);
      check("t5_quiet", rsp_valid, '0);
    end

    // All requesters valid: rotation must restart at 0 after the reset.
    rd_val = 32'hA5A5_0000;
    grants.delete();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = AW'(8'h80 + i);
      req_wdata[i*W +: W]  = W'(32'h1000 + i);
    end
    req_write = 4'b1010;
    @(posedge pclk); #1;
    req_valid = '1;
    for (int c = 0; c < 100; c++) begin
      @(negedge pclk); #1;
      if (grants.size() >= 8) break;
    end
    @(posedge pclk); #1;
    req_valid = '0;
    drain();
    check("t3_count", grants.size(), 8);
    for (int k = 0; k < 8; k++) begin
      check("t3_order", (k < grants.size()) ? grants[k] : -1, k % 4);
    end

`ifdef APB_TIMEOUT_EN
    // pready never comes: abandon after 16 ACCESS cycles.
    tmo_mode = 1; ws = 1000;
    issue(2, 8'h33, 32'h0, 1'b0);
    wait_rsp(cyc);
    check("t6_cycles", cyc, 18);
    check("t6_valid", rsp_valid, 4'b0100);
    check("t6_err", rsp_err, 1);
    check("t6_rdata", rsp_rdata, '0);
    @(negedge pclk);
    check("t6_idle_bus", {psel, penable}, 2'b00);
    tmo_mode = 0; ws = 0;
    drain();
`endif

    repeat (3) @(negedge pclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

endmodule
